playdriver: RTL and testbench
=============================

// Module: playdriver
// PURPOSE
//  Playback stage downstream of the record driver. On a rising edge of playEN it reads
//  the 1024x32 sample memory from word 0 upward and serialises each word MSB first.
//  Bits go out as a PDM stream on audPWM at the mic sample rate (2 MHz).
//  One clock domain: the bit rate is an internal clock-enable tick derived from big_clk.
// PARAMETERS
//  CLK_DIV  50    big_clk cycles per PDM bit (100 MHz -> 2 MHz); must be >= RD_LAT+3
//  DEPTH    1024  words in the sample memory; playback covers words 0..DEPTH-1
//  ADDR_W   10    memory address width; must satisfy DEPTH <= 2**ADDR_W
//  RD_LAT   1     memory read latency: rdata is valid RD_LAT cycles after mem_en/address
// PORTS
//  big_clk    in   1       system clock
//  reset      in   1       asynchronous, active-high reset
//  playEN     in   1       play request; only a 0->1 edge starts playback
//  rec_busy   in   1       flag_record from recorddriver; blocks playback start while 1
//  rdata      in   32      memory read data
//  mem_en     out  1       memory read enable, 1-cycle pulses
//  address    out  ADDR_W  memory read address
//  audPWM     out  1       PDM audio bit
//  audSD      out  1       audio amplifier enable; equals flag_play
//  flag_play  out  1       high while playback is in progress
// BEHAVIOUR
//  Reset: state=IDLE. playEN_reg=0, address=0, mem_en=0, audPWM=0, audSD=0, flag_play=0.
//   The divider, bit counter, shift register and next-word buffer are also cleared.
//  Edge detect: playEN_reg <= playEN every cycle. start = playEN & ~playEN_reg & ~rec_busy.
//  IDLE: edge sampled in cycle E with start=1 -> FETCH at E+1 (address=0, mem_en=1 for 1 cycle).
//   Any edge seen outside IDLE is ignored, including one in the cycle that returns to IDLE.
//  FETCH: waits RD_LAT cycles, then captures rdata into shreg and enters SHIFT.
//   In SHIFT the divider starts at 0 and word_idx=0.
//  SHIFT: the divider counts 0..CLK_DIV-1 and tick=1 when it reaches CLK_DIV-1.
//   On each tick: audPWM <= shreg[31], shreg <= shreg<<1, bitcnt++.
//   The first bit appears CLK_DIV cycles after SHIFT entry. Each bit is held exactly CLK_DIV cycles.
//  Prefetch: in the cycle after a word enters shreg, if word_idx < DEPTH-1, then
//   address <= word_idx+1 and mem_en pulses. rdata is captured into nbuf RD_LAT cycles later.
//  Word boundary, 32nd tick of word n < DEPTH-1: the bit is output, shreg <= nbuf, word_idx++.
//   The next tick outputs the new word's bit 31, so the stream has no gap.
//  Last word (word_idx=DEPTH-1): no prefetch, and mem_en stays 0.
//   The 32nd tick sets done. The following tick sets audPWM<=0 and state <= IDLE.
//   So the last bit is held a full period.
//  flag_play/audSD: 1 in every non-IDLE state, 0 in IDLE.
//  Playback length from SHIFT entry to IDLE: (DEPTH*32+1)*CLK_DIV cycles.
//  rec_busy rising during playback has no effect; the arbitration is at start only.
//  Reset mid-operation: immediate return to reset values.
//   A later edge restarts playback at word 0. There is no resume.
//  Counters: the divider needs ceil(log2(CLK_DIV)) bits, bitcnt is 5 bits, word_idx is ADDR_W bits.
//   word_idx never wraps past DEPTH-1.
// TESTING  (CLK_DIV=4, DEPTH=4, RD_LAT=1 memory model)
//  Reset: assert reset async mid-cycle -> every output is 0 immediately and stays 0 with playEN=0.
//  Basic play: mem={A5A50000,FFFFFFFF,00000000,80000001}, 1-cycle playEN pulse.
//   Required response: audPWM emits those 128 bits MSB first, each bit held 4 cycles, with no gaps.
//   Read addresses are 0,1,2,3 with one mem_en pulse each. flag_play falls (128+1)*4 cycles after SHIFT entry.
//  Level hold: playEN held at 1 throughout -> exactly one playback.
//   Dropping playEN and re-raising it after flag_play=0 -> a second identical playback.
//  Ignored starts: a playEN edge at bit 40 -> the stream is unchanged.
//   A playEN edge with rec_busy=1 -> flag_play stays 0 and mem_en stays 0.
//  Reset mid-word: reset at bit 50 -> audPWM=0 and flag_play=0 at once.
//   The next edge -> the first read is at address 0 and the output is A5A50000 from bit 31.
//  Boundary edge: playEN rises in the same cycle the FSM returns to IDLE -> no new playback.

Source files
------------

// File: rtl/playdriver.sv
// Playback driver: streams the sample memory out as a 1-bit PDM signal.
// A rising edge on playEN (when no recording is active) reads words 0..DEPTH-1
// and shifts each one out MSB first, one bit per CLK_DIV big_clk cycles.
// The next word is prefetched into a buffer so that the stream has no gaps.
module playdriver #(
  parameter int CLK_DIV = 50,
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int RD_LAT  = 1
) (
  input  logic              big_clk,
  input  logic              reset,
  input  logic              playEN,
  input  logic              rec_busy,
  input  logic [31:0]       rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] address,
  output logic              audPWM,
  output logic              audSD,
  output logic              flag_play
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LAT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

  localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [LAT_W-1:0]  LAT_MAX  = LAT_W'(RD_LAT);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_next_s;

  logic                play_en_r;      // playEN delayed one cycle for edge detection
  logic                start_s;        // qualified start request
  logic [LAT_W-1:0]    fetch_cnt_r;    // read latency counter for the first word
  logic                fetch_done_s;   // first word is on rdata this cycle
  logic [DIV_W-1:0]    div_r;          // bit-period divider
  logic                tick_s;         // one bit period has elapsed
  logic [4:0]          bitcnt_r;       // bit position within the current word
  logic                word_end_s;     // tick that emits bit 0 of a word
  logic [ADDR_W-1:0]   word_idx_r;     // index of the word currently in shreg_r
  logic                more_words_s;   // another word follows the current one
  logic [31:0]         shreg_r;        // word being serialised, MSB at the top
  logic [31:0]         nbuf_r;         // prefetched next word
  logic                new_word_r;     // shreg_r was loaded in the previous cycle
  logic                prefetch_s;     // issue the read for the next word now
  logic                nb_pend_r;      // prefetch read in flight
  logic [LAT_W-1:0]    nb_cnt_r;       // latency counter for the prefetch read
  logic                done_r;         // last bit of the last word is being held

  logic                mem_en_r;
  logic [ADDR_W-1:0]   address_r;
  logic                aud_pwm_r;
  logic                flag_play_r;

  assign start_s      = playEN & ~play_en_r & ~rec_busy;
  assign fetch_done_s = (state_r == ST_FETCH) && (fetch_cnt_r == LAT_MAX);
  assign tick_s       = (state_r == ST_SHIFT) && (div_r == DIV_MAX);
  assign word_end_s   = tick_s && (bitcnt_r == 5'd31);
  assign more_words_s = (word_idx_r < LAST_IDX);
  assign prefetch_s   = (state_r == ST_SHIFT) && new_word_r && more_words_s;

  // Next-state logic: start only from IDLE, leave SHIFT one tick after the last bit
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (fetch_done_s) begin
          state_next_s = ST_SHIFT;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_SHIFT: begin
        if (tick_s && done_r) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge big_clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // playEN history for rising-edge detection
  always_ff @(posedge big_clk or posedge reset) begin
    if (reset) begin
      play_en_r <= 1'b0;
    end else begin
      play_en_r <= playEN;
    end
  end

  // Count read latency while waiting for the first word
  always_ff @(posedge big_clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_r <= {LAT_W{1'b0}};
    end else if ((state_r == ST_FETCH) && !fetch_done_s) begin
      fetch_cnt_r <= fetch_cnt_r + LAT_W'(1);
    end else begin
      fetch_cnt_r <= {LAT_W{1'b0}};
    end
  end

  // Bit-period divider, held at zero outside SHIFT so each word stream starts aligned
  always_ff @(posedge big_clk or posedge reset) begin
    if (reset) begin
      div_r <= {DIV_W{1'b0}};
    end else if (state_r != ST_SHIFT) begin
      div_r <= {DIV_W{1'b0}};
    end else if (tick_s) begin
      div_r <= {DIV_W{1'b0}};
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  // Bit position within the current word; wraps naturally after bit 0
  always_ff @(posedge big_clk or posedge reset) begin
    if (reset) begin
      bitcnt_r <= 5'd0;
    end else if (state_r != ST_SHIFT) begin
      bitcnt_r <= 5'd0;
    end else if (tick_s) begin
      bitcnt_r <= bitcnt_r + 5'd1;
    end else begin
      bitcnt_r <= bitcnt_r;
    end
  end

  // Shift register, word index and end-of-stream flag
  always_ff @(posedge big_clk or posedge reset) begin
    if (reset) begin
      shreg_r    <= 32'd0;
      word_idx_r <= {ADDR_W{1'b0}};
      done_r     <= 1'b0;
      new_word_r <= 1'b0;
    end else begin
      new_word_r <= 1'b0;
      if (fetch_done_s) begin
        shreg_r    <= rdata;
        word_idx_r <= {ADDR_W{1'b0}};
        done_r     <= 1'b0;
        new_word_r <= 1'b1;
      end else if (tick_s && !done_r) begin
        if (word_end_s && more_words_s) begin
          // Seamless hand-over: the next tick emits bit 31 of the buffered word
          shreg_r    <= nbuf_r;
          word_idx_r <= word_idx_r + ADDR_ONE;
          new_word_r <= 1'b1;
        end else begin
          shreg_r <= {shreg_r[30:0], 1'b0};
          done_r  <= word_end_s;
        end
      end else if (state_r == ST_IDLE) begin
        word_idx_r <= {ADDR_W{1'b0}};
        done_r     <= 1'b0;
      end else begin
        shreg_r <= shreg_r;
      end
    end
  end

  // Capture the prefetched word once its read latency has elapsed
  always_ff @(posedge big_clk or posedge reset) begin
    if (reset) begin
      nbuf_r    <= 32'd0;
      nb_pend_r <= 1'b0;
      nb_cnt_r  <= {LAT_W{1'b0}};
    end else if (state_r == ST_IDLE) begin
      nb_pend_r <= 1'b0;
      nb_cnt_r  <= {LAT_W{1'b0}};
    end else if (prefetch_s) begin
      nb_pend_r <= 1'b1;
      nb_cnt_r  <= {LAT_W{1'b0}};
    end else if (nb_pend_r) begin
      if (nb_cnt_r == LAT_MAX) begin
        nbuf_r    <= rdata;
        nb_pend_r <= 1'b0;
      end else begin
        nb_cnt_r <= nb_cnt_r + LAT_W'(1);
      end
    end else begin
      nb_pend_r <= 1'b0;
    end
  end

  // Memory read port: one-cycle enable pulses for the first word and each prefetch
  always_ff @(posedge big_clk or posedge reset) begin
    if (reset) begin
      mem_en_r  <= 1'b0;
      address_r <= {ADDR_W{1'b0}};
    end else if ((state_r == ST_IDLE) && start_s) begin
      mem_en_r  <= 1'b1;
      address_r <= {ADDR_W{1'b0}};
    end else if (prefetch_s) begin
      mem_en_r  <= 1'b1;
      address_r <= word_idx_r + ADDR_ONE;
    end else begin
      mem_en_r  <= 1'b0;
      address_r <= address_r;
    end
  end

  // PDM output bit: updated on ticks, forced low once the last bit has been held
  always_ff @(posedge big_clk or posedge reset) begin
    if (reset) begin
      aud_pwm_r <= 1'b0;
    end else if (tick_s) begin
      aud_pwm_r <= done_r ? 1'b0 : shreg_r[31];
    end else if (state_r == ST_IDLE) begin
      aud_pwm_r <= 1'b0;
    end else begin
      aud_pwm_r <= aud_pwm_r;
    end
  end

  // Playback-active flag, registered from the next state so it tracks non-IDLE exactly
  always_ff @(posedge big_clk or posedge reset) begin
    if (reset) begin
      flag_play_r <= 1'b0;
    end else begin
      flag_play_r <= (state_next_s != ST_IDLE);
    end
  end

  assign mem_en    = mem_en_r;
  assign address   = address_r;
  assign audPWM    = aud_pwm_r;
  assign flag_play = flag_play_r;
  assign audSD     = flag_play_r;

endmodule

// File: tb/tb_playdriver.sv
// Self-checking bench for playdriver with a small 4-word memory.
// The expected PDM stream is computed from the memory contents and the
// bit timing rules; read addresses are collected and compared as a list.
module tb_playdriver;

  localparam int CLK_DIV  = 4;
  localparam int DEPTH    = 4;
  localparam int ADDR_W   = 2;
  localparam int RD_LAT   = 1;
  localparam int NBITS    = DEPTH * 32;
  localparam int SHIFT_AT = RD_LAT + 1;                         // cycles from flag_play rise to SHIFT entry
  localparam int END_C    = SHIFT_AT + (NBITS + 1) * CLK_DIV;   // first cycle back in IDLE

  logic              big_clk  = 1'b0;
  logic              reset    = 1'b0;
  logic              playEN   = 1'b0;
  logic              rec_busy = 1'b0;
  logic [31:0]       rdata    = 32'd0;
  logic              mem_en;
  logic [ADDR_W-1:0] address;
  logic              audPWM;
  logic              audSD;
  logic              flag_play;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] rd_q [$];

  int total = 0;
  int bad   = 0;

  playdriver #(
    .CLK_DIV(CLK_DIV),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .big_clk  (big_clk),
    .reset    (reset),
    .playEN   (playEN),
    .rec_busy (rec_busy),
    .rdata    (rdata),
    .mem_en   (mem_en),
    .address  (address),
    .audPWM   (audPWM),
    .audSD    (audSD),
    .flag_play(flag_play)
  );

  always #5 big_clk = ~big_clk;

  // Memory with one cycle of read latency
  always @(posedge big_clk) begin
    if (mem_en === 1'b1) rdata <= mem[address];
  end

  // Log every read address
  always @(posedge big_clk) begin
    if (mem_en === 1'b1) rd_q.push_back(address);
  end

  // Expected audPWM in cycle c, counted from the first cycle flag_play is high
  function automatic logic exp_pwm(input int c);
    int k;
    if (c < SHIFT_AT + CLK_DIV) return 1'b0;
    k = (c - SHIFT_AT) / CLK_DIV - 1;
    if (k >= NBITS) return 1'b0;
    return mem[k / 32][31 - (k % 32)];
  endfunction

  task automatic start_play(input string nm, output bit ok);
    int lat;
    lat = 0;
    @(negedge big_clk);
    playEN = 1'b1;
    do begin
      @(negedge big_clk);
      lat++;
    end while (flag_play !== 1'b1 && lat < 10);
    total++;
    if (lat !== 1) begin
      bad++;
      $display("FAIL %s start_latency: got %0d cycles, want 1", nm, lat);
    end
    ok = (flag_play === 1'b1);
  endtask

  // Walks a whole playback cycle by cycle; the poke arguments inject events at given cycles
  task automatic check_stream(input string nm, input int low_c, input int pulse_c,
                              input int busy_c, input int rst_c, input int hi_c);
    int errs, first_bad, fall_c, base, n;
    bit aborted, addr_ok;
    logic exp_f;
    errs = 0; first_bad = -1; fall_c = -1; aborted = 1'b0;
    base = rd_q.size();
    for (int c = 0; c < END_C + 4; c++) begin
      exp_f = (c < END_C) ? 1'b1 : 1'b0;
      if (audPWM !== exp_pwm(c) || flag_play !== exp_f || audSD !== exp_f) begin
        errs++;
        if (first_bad < 0) first_bad = c;
      end
      if (flag_play === 1'b0 && fall_c < 0) fall_c = c;
      if (c == low_c) playEN = 1'b0;
      if (c == pulse_c) playEN = 1'b1;
      if (pulse_c >= 0 && c == pulse_c + 1) playEN = 1'b0;
      if (c == busy_c) rec_busy = 1'b1;
      if (c == hi_c) playEN = 1'b1;
      if (c == rst_c) begin
        #2 reset = 1'b1;
        #1;
        total++;
        if ({audPWM, flag_play, audSD, mem_en} !== 4'b0000) begin
          bad++;
          $display("FAIL %s async_reset: got pwm/flag/sd/en=%b, want 0000", nm,
                   {audPWM, flag_play, audSD, mem_en});
        end
        aborted = 1'b1;
        break;
      end
      @(negedge big_clk);
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL %s stream: %0d bad cycles (first at cycle %0d), want 0", nm, errs, first_bad);
    end
    if (!aborted) begin
      total++;
      if (fall_c !== END_C) begin
        bad++;
        $display("FAIL %s flag_fall: got cycle %0d, want %0d", nm, fall_c, END_C);
      end
      n = rd_q.size() - base;
      addr_ok = (n == DEPTH);
      for (int i = 0; i < n && i < DEPTH; i++) begin
        if (rd_q[base + i] !== ADDR_W'(i)) addr_ok = 1'b0;
      end
      total++;
      if (!addr_ok) begin
        bad++;
        $display("FAIL %s read_addresses: got %0d reads (first %0d), want %0d reads 0..%0d",
                 nm, n, (n > 0) ? int'(rd_q[base]) : -1, DEPTH, DEPTH - 1);
      end
    end
  endtask

  task automatic check_idle(input string nm, input int cycles);
    int errs;
    errs = 0;
    repeat (cycles) begin
      @(negedge big_clk);
      if (flag_play !== 1'b0 || audSD !== 1'b0 || audPWM !== 1'b0 || mem_en !== 1'b0) errs++;
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL %s idle: %0d active cycles, want 0", nm, errs);
    end
  endtask

  task automatic load_basic();
    mem[0] = 32'hA5A50000;
    mem[1] = 32'hFFFFFFFF;
    mem[2] = 32'h00000000;
    mem[3] = 32'h80000001;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    total++;
    if ({audPWM, flag_play, audSD, mem_en, address} !== 6'b000000) begin
      bad++;
      $display("FAIL reset_values: got %b, want 000000", {audPWM, flag_play, audSD, mem_en, address});
    end
    repeat (3) @(negedge big_clk);
    reset = 1'b0;
    check_idle("reset_hold", 12);
  endtask

  task automatic test_basic();
    bit ok;
    load_basic();
    start_play("basic", ok);
    if (ok) check_stream("basic", 0, -1, -1, -1, -1);
    playEN = 1'b0;
    check_idle("basic_after", 10);
  endtask

  task automatic test_level_hold();
    bit ok;
    load_basic();
    start_play("hold1", ok);
    if (ok) check_stream("hold1", -1, -1, -1, -1, -1);
    check_idle("hold_level", 30);
    playEN = 1'b0;
    repeat (3) @(negedge big_clk);
    start_play("hold2", ok);
    if (ok) check_stream("hold2", 0, -1, -1, -1, -1);
    playEN = 1'b0;
  endtask

  task automatic test_ignored_edge();
    bit ok;
    load_basic();
    start_play("edge_bit40", ok);
    if (ok) check_stream("edge_bit40", 0, SHIFT_AT + 41 * CLK_DIV, -1, -1, -1);
    playEN = 1'b0;
  endtask

  task automatic test_rec_busy();
    int base;
    base = rd_q.size();
    @(negedge big_clk);
    rec_busy = 1'b1;
    @(negedge big_clk);
    playEN = 1'b1;
    check_idle("busy_block", 20);
    playEN = 1'b0;
    check_idle("busy_low", 3);
    rec_busy = 1'b0;
    check_idle("busy_clear", 5);
    total++;
    if (rd_q.size() !== base) begin
      bad++;
      $display("FAIL busy_reads: got %0d reads, want 0", rd_q.size() - base);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    load_basic();
    start_play("rst_bit50", ok);
    if (ok) check_stream("rst_bit50", 0, -1, -1, SHIFT_AT + 51 * CLK_DIV + 1, -1);
    playEN = 1'b0;
    repeat (3) @(negedge big_clk);
    reset = 1'b0;
    check_idle("rst_hold", 5);
    start_play("rst_restart", ok);
    if (ok) check_stream("rst_restart", 0, -1, -1, -1, -1);
    playEN = 1'b0;
  endtask

  task automatic test_boundary();
    bit ok;
    load_basic();
    start_play("boundary", ok);
    if (ok) check_stream("boundary", 0, -1, -1, -1, END_C - 1);
    check_idle("boundary_after", 30);
    playEN = 1'b0;
    check_idle("boundary_drop", 3);
  endtask

  task automatic test_random();
    bit ok;
    int w, busy_at;
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      repeat ($urandom_range(0, 7)) @(negedge big_clk);
      w = $urandom_range(1, 3);
      busy_at = $urandom_range(10, END_C - 10);
      start_play("random", ok);
      if (ok) check_stream("random", w - 1, -1, busy_at, -1, -1);
      playEN = 1'b0;
      rec_busy = 1'b0;
      check_idle("random_after", 5);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_level_hold();
    test_ignored_edge();
    test_rec_busy();
    test_reset_mid();
    test_boundary();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
